// File: rtl/clock_set_controller.sv
// Control block for the hh:mm:ss counter: 1 Hz prescaler, button-driven time-set FSM
// with shadow hour/minute fields, one-cycle parallel-load strobe and edit-field blink.
module clock_set_controller #(
   parameter int TICK_DIV = 50_000_000,
   parameter int HR_MAX   = 23,
   parameter int MIN_MAX  = 59
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [4:0] cur_hr,
   input  logic [5:0] cur_min,
   output logic       tick_en,
   output logic       load,
   output logic [4:0] load_hr,
   output logic [5:0] load_min,
   output logic [5:0] load_sec,
   output logic [1:0] mode,
   output logic       blink
);
   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(TICK_DIV / 2);
   localparam logic [4:0]    HR_TOP   = 5'(HR_MAX);
   localparam logic [5:0]    MIN_TOP  = 6'(MIN_MAX);

   localparam logic [1:0] RUN     = 2'd0;
   localparam logic [1:0] SET_HR  = 2'd1;
   localparam logic [1:0] SET_MIN = 2'd2;

   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]    mode_nxt;
   logic [4:0]    shr, shr_nxt;
   logic [5:0]    smin, smin_nxt;
   logic          hist_mode, hist_inc;
   logic          mode_edge, inc_edge;
   logic          restart, do_load;

   always_comb begin
      mode_edge = btn_mode & ~hist_mode;
      inc_edge  = btn_inc & ~hist_inc;
      mode_nxt  = mode;
      shr_nxt   = shr;
      smin_nxt  = smin;
      restart   = 1'b0;
      do_load   = 1'b0;
      // mode edge is tested first so a coincident inc edge is dropped
      case (mode)
         RUN: begin
            if (mode_edge) begin
               mode_nxt = SET_HR;
               shr_nxt  = cur_hr;
               smin_nxt = cur_min;
               restart  = 1'b1;
            end
         end
         SET_HR: begin
            if (mode_edge)
               mode_nxt = SET_MIN;
            else if (inc_edge)
               shr_nxt = (shr >= HR_TOP) ? 5'd0 : shr + 5'd1;
         end
         SET_MIN: begin
            if (mode_edge) begin
               mode_nxt = RUN;
               do_load  = 1'b1;
               restart  = 1'b1;
            end else if (inc_edge)
               smin_nxt = (smin >= MIN_TOP) ? 6'd0 : smin + 6'd1;
         end
         default: mode_nxt = RUN;
      endcase
      cnt_nxt = (restart || cnt == CNT_LAST) ? '0 : cnt + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode      <= RUN;
         cnt       <= '0;
         tick_en   <= 1'b0;
         load      <= 1'b0;
         load_hr   <= '0;
         load_min  <= '0;
         load_sec  <= '0;
         blink     <= 1'b0;
         shr       <= '0;
         smin      <= '0;
         hist_mode <= 1'b1;
         hist_inc  <= 1'b1;
      end else begin
         mode      <= mode_nxt;
         cnt       <= cnt_nxt;
         tick_en   <= (cnt == CNT_LAST) && (mode == RUN);
         load      <= do_load;
         shr       <= shr_nxt;
         smin      <= smin_nxt;
         hist_mode <= btn_mode;
         hist_inc  <= btn_inc;
         if (do_load) begin
            load_hr  <= shr;
            load_min <= smin;
            load_sec <= '0;
         end
         // blink tracks the registered prescaler/mode pair it is shown with
         blink <= ((mode_nxt == SET_HR) || (mode_nxt == SET_MIN)) && (cnt_nxt >= CNT_HALF);
      end
   end
endmodule
